// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared constants, channel id type and round-robin pick function
// for the 4-channel round-robin merge stage.
//   WIDTH_DEF : default data width
//   N_CH      : number of merged channels
//   ch_id_t   : channel index type
//   rr_pick   : first requesting channel after 'last', wrapping round to 'last'
package mux_rr_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int N_CH = 4;
   typedef logic [1:0] ch_id_t;
   // Rotate the request vector so bit 0 is channel last+1, take the lowest set
   // bit, and rotate the index back. With no request the result is 'last'.
   function automatic ch_id_t rr_pick(input logic [N_CH-1:0] req, input ch_id_t last);
      ch_id_t base;
      ch_id_t k;
      logic [N_CH-1:0] rot;
      base = last + 2'd1;
      rot = 4'({req, req} >> base);
      k = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
      return base + k;
   endfunction
endpackage

// File: rtl/mux_rr_4x8_if.sv
// mux_rr_4x8_if: bundle of the four source channels and the merged output.
//   in0..in3  : channel data (source -> merge)
//   in_valid  : per-channel offer (source -> merge)
//   in_ready  : per-channel accept (merge -> source)
//   out       : merged data (merge -> sink)
//   out_sel   : channel index of 'out' (merge -> sink)
//   out_valid : 'out' holds a byte (merge -> sink)
//   out_ready : sink accepts (sink -> merge)
// Modports: slave = merge block, master = surrounding sources and sink.
interface mux_rr_4x8_if
   import mux_rr_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF);
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [N_CH-1:0]  in_valid;
   logic [N_CH-1:0]  in_ready;
   logic [WIDTH-1:0] out;
   ch_id_t           out_sel;
   logic             out_valid;
   logic             out_ready;
   modport slave (input in0, in1, in2, in3, in_valid, out_ready,
                  output in_ready, out, out_sel, out_valid);
   modport master (output in0, in1, in2, in3, in_valid, out_ready,
                   input in_ready, out, out_sel, out_valid);
endinterface

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way round-robin arbiter.
//   req    : request vector
//   last   : most recently granted channel (lowest priority this cycle)
//   en     : grant enable; with en low gnt is all zero
//   gnt    : one-hot grant, zero when no request or not enabled
//   gnt_id : index of the granted channel (meaningful only when gnt != 0)
module rr_arb4
   import mux_rr_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  ch_id_t          last,
   input  logic            en,
   output logic [N_CH-1:0] gnt,
   output ch_id_t          gnt_id
);
   assign gnt_id = rr_pick(req, last);
   assign gnt = (en && |req) ? (4'b0001 << gnt_id) : 4'b0000;
endmodule

// File: rtl/mux_rr_4x8.sv
// mux_rr_4x8: round-robin merge of four valid/ready byte channels into one
// registered output tagged with the source channel.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : channel inputs, per-channel ready, registered out/out_sel/out_valid
module mux_rr_4x8
   import mux_rr_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF)
(
   input logic          clk,
   input logic          rst_n,
   mux_rr_4x8_if.slave  bus
);
   logic            load_en;
   logic [N_CH-1:0] gnt;
   ch_id_t          gnt_id;
   ch_id_t          last;
   logic [WIDTH-1:0] sel_data;
   // Gated by rst_n so no source sees a ready while the block is held in reset.
   assign load_en = rst_n && (!bus.out_valid || bus.out_ready);
   rr_arb4 u_arb (
      .req    (bus.in_valid),
      .last   (last),
      .en     (load_en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );
   assign bus.in_ready = gnt;
   always_comb
      sel_data = (gnt_id == 2'd0) ? bus.in0 :
                 (gnt_id == 2'd1) ? bus.in1 :
                 (gnt_id == 2'd2) ? bus.in2 : bus.in3;
   // A new accept takes priority over draining, so drain+accept keeps out_valid.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.out       <= '0;
         bus.out_sel   <= 2'd0;
         bus.out_valid <= 1'b0;
         last          <= 2'd3;
      end else if (|gnt) begin
         bus.out       <= sel_data;
         bus.out_sel   <= gnt_id;
         bus.out_valid <= 1'b1;
         last          <= gnt_id;
      end else if (bus.out_ready)
         bus.out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_rr_4x8.sv
// tb_mux_rr_4x8: self-checking bench for mux_rr_4x8 (directed table,
// hand-written reset/stall sequence, randomized traffic against a model).
module tb_mux_rr_4x8;
   import mux_rr_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   mux_rr_4x8_if bus ();
   mux_rr_4x8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic       m_valid;
   logic [7:0] m_out;
   int         m_sel;
   int         m_last;
   int         m_gnt;

   typedef struct {
      logic [3:0]      v;
      logic            r;
      logic [3:0][7:0] d;
      logic [3:0]      rdy;
      logic            ev;
      logic [7:0]      eo;
      logic [1:0]      es;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic r, input logic [31:0] d,
                      input logic [3:0] rdy, input logic ev, input logic [7:0] eo,
                      input logic [1:0] es);
      vec_t x;
      x.v = v; x.r = r; x.d = d; x.rdy = rdy; x.ev = ev; x.eo = eo; x.es = es;
      tbl.push_back(x);
   endtask

   task automatic set_in(input logic [3:0] v, input logic r, input logic [3:0][7:0] d);
      bus.in_valid = v;
      bus.out_ready = r;
      bus.in0 = d[0];
      bus.in1 = d[1];
      bus.in2 = d[2];
      bus.in3 = d[3];
   endtask

   // Channel order after 'last': last+1, last+2, last+3, last; -1 if none.
   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++)
         if (v[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_rdy();
      int g;
      g = pick(bus.in_valid, m_last);
      if (rst_n && (!m_valid || bus.out_ready) && g >= 0) return 4'(1 << g);
      return 4'b0000;
   endfunction

   function automatic logic [7:0] chan_data(input int c);
      return c == 0 ? bus.in0 : c == 1 ? bus.in1 : c == 2 ? bus.in2 : bus.in3;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_out = 8'h00; m_sel = 0; m_last = 3; m_gnt = -1;
   endtask

   task automatic model_check();
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out", 32'(bus.out), 32'(m_out));
      chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
   endtask

   task automatic clock_edge();
      logic [7:0] d;
      m_gnt = (exp_rdy() != 4'b0000) ? pick(bus.in_valid, m_last) : -1;
      d = (m_gnt >= 0) ? chan_data(m_gnt) : 8'h00;
      @(posedge clk);
      if (m_gnt >= 0) begin
         m_out = d; m_sel = m_gnt; m_valid = 1'b1; m_last = m_gnt;
      end else if (bus.out_ready)
         m_valid = 1'b0;
      #1;
   endtask

   initial begin
      logic [3:0]      pend;
      logic [3:0][7:0] pd;
      model_reset();
      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         set_in(4'($urandom), 1'($urandom), $urandom);
         @(negedge clk);
         chk("rst_out", 32'(bus.out), 32'h00);
         chk("rst_sel", 32'(bus.out_sel), 32'd0);
         chk("rst_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_ready", 32'(bus.in_ready), 32'd0);
      end
      rst_n = 1'b1;
      set_in(4'b0000, 1'b0, 32'h0);
      clock_edge();

      // streaming, channel 0 first after reset
      add(4'b1111, 1, 32'hA3A2A1A0, 4'b0001, 0, 8'h00, 2'd0);
      add(4'b1111, 1, 32'hA3A2A1A0, 4'b0010, 1, 8'hA0, 2'd0);
      add(4'b1111, 1, 32'hA3A2A1A0, 4'b0100, 1, 8'hA1, 2'd1);
      add(4'b1111, 1, 32'hA3A2A1A0, 4'b1000, 1, 8'hA2, 2'd2);
      // sparse 1/3 with last = 3
      add(4'b1010, 1, 32'hA3A2A1A0, 4'b0010, 1, 8'hA3, 2'd3);
      add(4'b1010, 1, 32'hA3A2A1A0, 4'b1000, 1, 8'hA1, 2'd1);
      add(4'b1010, 1, 32'hA3A2A1A0, 4'b0010, 1, 8'hA3, 2'd3);
      add(4'b1010, 1, 32'hA3A2A1A0, 4'b1000, 1, 8'hA1, 2'd1);
      // drain, then load 0x55 and stall for 5 cycles
      add(4'b0000, 1, 32'h00000000, 4'b0000, 1, 8'hA3, 2'd3);
      add(4'b0001, 0, 32'h00000055, 4'b0001, 0, 8'hA3, 2'd3);
      for (int i = 0; i < 5; i++)
         add(4'b1111, 0, 32'hB3B2B1B0, 4'b0000, 1, 8'h55, 2'd0);
      // out_ready rises: next byte loads on that edge
      add(4'b1111, 1, 32'hB3B2B1B0, 4'b0010, 1, 8'h55, 2'd0);
      // simultaneous drain and accept of channel 2
      add(4'b0100, 1, 32'h003C0000, 4'b0100, 1, 8'hB1, 2'd1);
      add(4'b0000, 0, 32'h00000000, 4'b0000, 1, 8'h3C, 2'd2);
      foreach (tbl[i]) begin
         set_in(tbl[i].v, tbl[i].r, tbl[i].d);
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].eo));
         chk($sformatf("tbl%0d_sel", i), 32'(bus.out_sel), 32'(tbl[i].es));
         clock_edge();
      end

      // reset asserted mid-stall
      set_in(4'b1111, 1'b0, 32'hC3C2C1C0);
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out", 32'(bus.out), 32'h3C);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out", 32'(bus.out), 32'h00);
      chk("arst_sel", 32'(bus.out_sel), 32'd0);
      chk("arst_ready", 32'(bus.in_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'b0001);
      clock_edge();
      @(negedge clk);
      chk("post_rst_sel", 32'(bus.out_sel), 32'd0);
      chk("post_rst_out", 32'(bus.out), 32'hC0);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
      clock_edge();

      // randomized traffic; sources hold valid/data until accepted
      pend = 4'b0000;
      pd = '0;
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < 4; c++)
            if (!pend[c] && $urandom_range(0, 1) == 1) begin
               pend[c] = 1'b1;
               pd[c] = 8'($urandom);
            end
         set_in(pend, $urandom_range(0, 3) != 0, pd);
         @(negedge clk);
         model_check();
         clock_edge();
         if (m_gnt >= 0) pend[m_gnt] = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
